// File: rtl/beat_scheduler.sv
// Beat sequencer: programmable beat divider, play/pause, direction
// and a captured loop window driving the music ROM beat index.
module beat_scheduler #(
  parameter int LEN      = 64,
  parameter int BASE_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_1p,
  input  logic        speed_up_1p,
  input  logic        speed_down_1p,
  input  logic        loop_en,
  input  logic [2:0]  loop_width,
  input  logic        reverse,
  output logic [11:0] ibeat,
  output logic        beat_tick,
  output logic        playing,
  output logic        loop_active,
  output logic [2:0]  speed_level
);

  typedef enum logic [1:0] {
    PAUSED,
    PLAYING,
    LOOPING
  } state_e;

  localparam logic [11:0] LAST  = 12'(LEN - 1);
  localparam logic [12:0] LEN13 = 13'(LEN);
  localparam logic [33:0] DIV0  = 34'(BASE_DIV) << 2;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [11:0] ibeat_q, ibeat_d;
  logic [11:0] start_q, start_d;
  logic [2:0]  speed_q, speed_d;
  logic        tick_q, tick_d;
  logic        play_q, play_d;
  logic        loop_q, loop_d;

  logic [33:0] div;
  logic        term;
  logic        adv;
  logic [2:0]  w;
  logic        wrap_all;
  logic [12:0] end_sum;
  logic [11:0] loop_end;
  logic [11:0] fwd, rev;

  always_comb begin
    w = loop_width;
    if (loop_width < 3'd2) w = 3'd2;
    if (loop_width > 3'd6) w = 3'd6;
    // a song shorter than the window just wraps normally
    wrap_all = LEN13 < {10'd0, w};
    end_sum  = {1'b0, start_q} + {10'd0, w} - 13'd1;
    loop_end = (end_sum >= LEN13) ? 12'(end_sum - LEN13)
                                  : end_sum[11:0];
    fwd  = (ibeat_q == LAST) ? 12'd0 : ibeat_q + 12'd1;
    rev  = (ibeat_q == 12'd0) ? LAST : ibeat_q - 12'd1;
    div  = DIV0 >> speed_q;
    term = {2'b00, cnt_q} >= (div - 34'd1);
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    ibeat_d = ibeat_q;
    speed_d = speed_q;
    tick_d  = 1'b0;
    adv     = 1'b0;

    unique case (1'b1)
      speed_up_1p && !speed_down_1p && speed_q != 3'd4:
        speed_d = speed_q + 3'd1;
      speed_down_1p && !speed_up_1p && speed_q != 3'd0:
        speed_d = speed_q - 3'd1;
      default: ;
    endcase

    unique case (state_q)
      PAUSED: begin
        if (play_1p) begin
          state_d = loop_en ? LOOPING : PLAYING;
          if (loop_en) start_d = ibeat_q;
        end
      end
      PLAYING: begin
        if (play_1p) begin
          state_d = PAUSED;
        end else if (loop_en) begin
          state_d = LOOPING;
          start_d = ibeat_q;
        end
      end
      LOOPING: begin
        if (play_1p) state_d = PAUSED;
        else if (!loop_en) state_d = PLAYING;
      end
      default: state_d = PAUSED;
    endcase

    // a pause request beats a coincident advance
    if (state_q == PAUSED || play_1p) begin
      cnt_d = '0;
    end else if (term) begin
      cnt_d = '0;
      adv   = 1'b1;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    if (adv) begin
      tick_d = 1'b1;
      if (state_q == LOOPING && !wrap_all) begin
        if (reverse)
          ibeat_d = (ibeat_q == start_q) ? loop_end : rev;
        else
          ibeat_d = (ibeat_q == loop_end) ? start_q : fwd;
      end else begin
        ibeat_d = reverse ? rev : fwd;
      end
    end

    play_d = state_d != PAUSED;
    loop_d = state_d == LOOPING;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PAUSED;
      cnt_q   <= '0;
      ibeat_q <= '0;
      start_q <= '0;
      speed_q <= 3'd2;
      tick_q  <= 1'b0;
      play_q  <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ibeat_q <= ibeat_d;
      start_q <= start_d;
      speed_q <= speed_d;
      tick_q  <= tick_d;
      play_q  <= play_d;
      loop_q  <= loop_d;
    end
  end

  assign ibeat       = ibeat_q;
  assign beat_tick   = tick_q;
  assign playing     = play_q;
  assign loop_active = loop_q;
  assign speed_level = speed_q;

endmodule

// File: tb/tb_beat_scheduler.sv
// Scoreboard bench for beat_scheduler: expected beats queued with
// stimulus, compared with the beat recorded at each beat_tick.
module tb_beat_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        play_1p;
  logic        speed_up_1p;
  logic        speed_down_1p;
  logic        loop_en;
  logic [2:0]  loop_width;
  logic        reverse;
  logic [11:0] ibeat;
  logic        beat_tick;
  logic        playing;
  logic        loop_active;
  logic [2:0]  speed_level;

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;
  int ntick   = 0;
  int seen    = 0;
  int last_c  = 0;
  int tick_cyc [256];
  int tick_beat[256];
  int exp_q[$];

  beat_scheduler #(
    .LEN(16),
    .BASE_DIV(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .play_1p(play_1p),
    .speed_up_1p(speed_up_1p),
    .speed_down_1p(speed_down_1p),
    .loop_en(loop_en),
    .loop_width(loop_width),
    .reverse(reverse),
    .ibeat(ibeat),
    .beat_tick(beat_tick),
    .playing(playing),
    .loop_active(loop_active),
    .speed_level(speed_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && beat_tick) begin
      if (ntick < 256) begin
        tick_cyc[ntick]  <= cyc;
        tick_beat[ntick] <= int'(ibeat);
      end
      ntick <= ntick + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic p, input logic u, input logic d);
    play_1p       = p;
    speed_up_1p   = u;
    speed_down_1p = d;
    step(1);
    play_1p       = 1'b0;
    speed_up_1p   = 1'b0;
    speed_down_1p = 1'b0;
  endtask

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic push_range(input int a, input int b);
    for (int v = a; v <= b; v++) exp_q.push_back(v);
  endtask

  task automatic wait_tick(input int per);
    int n;
    int c;
    n = 0;
    while (ntick <= seen && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (ntick <= seen) begin
      check("tick_timeout", ntick, seen + 1);
      return;
    end
    c = tick_cyc[seen];
    if (exp_q.size() == 0)
      check("sb_empty", exp_q.size(), 1);
    else
      check("ibeat", tick_beat[seen], exp_q.pop_front());
    if (per != 0) check("period", c - last_c, per);
    last_c = c;
    seen++;
  endtask

  initial begin
    rst           = 1'b1;
    play_1p       = 1'b0;
    speed_up_1p   = 1'b0;
    speed_down_1p = 1'b0;
    loop_en       = 1'b0;
    loop_width    = 3'd3;
    reverse       = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_ibeat", int'(ibeat), 0);
    check("rst_tick", int'(beat_tick), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_loop", int'(loop_active), 0);
    check("rst_speed", int'(speed_level), 2);
    step(2);
    rst = 1'b1;
    step(3);
    check("idle_ibeat", int'(ibeat), 0);
    check("idle_playing", int'(playing), 0);

    push_range(1, 15);
    push(0);
    push(1);
    pulse(1'b1, 1'b0, 1'b0);
    check("play_on", int'(playing), 1);
    last_c = cyc;
    repeat (17) wait_tick(8);
    check("speed_init", int'(speed_level), 2);

    push_range(2, 5);
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b1);
    check("speed_sat4", int'(speed_level), 4);
    wait_tick(0);
    repeat (3) wait_tick(2);

    push_range(6, 7);
    repeat (5) pulse(1'b0, 1'b0, 1'b1);
    check("speed_sat0", int'(speed_level), 0);
    wait_tick(0);
    wait_tick(32);

    push_range(8, 15);
    push_range(0, 5);
    pulse(1'b0, 1'b1, 1'b1);
    check("speed_updown", int'(speed_level), 0);
    repeat (2) pulse(1'b0, 1'b1, 1'b0);
    check("speed_back2", int'(speed_level), 2);
    wait_tick(0);
    repeat (13) wait_tick(8);

    push(6); push(7); push(5); push(6); push(7); push(5);
    loop_en = 1'b1;
    repeat (6) wait_tick(8);
    check("loop_on", int'(loop_active), 1);

    push_range(6, 9);
    loop_en = 1'b0;
    repeat (4) wait_tick(8);
    check("loop_off", int'(loop_active), 0);

    push(10); push(9); push(10); push(9);
    loop_width = 3'd0;
    loop_en    = 1'b1;
    repeat (4) wait_tick(8);

    push_range(10, 15);
    push(0);
    push(1);
    loop_en    = 1'b0;
    loop_width = 3'd3;
    repeat (8) wait_tick(8);

    push(0); push(15); push(14);
    reverse = 1'b1;
    repeat (3) wait_tick(8);

    push(15); push(0); push(1); push(14); push(15);
    loop_en    = 1'b1;
    loop_width = 3'd4;
    reverse    = 1'b0;
    repeat (5) wait_tick(8);

    push(14); push(1); push(0); push(15); push(14);
    reverse = 1'b1;
    repeat (5) wait_tick(8);
    check("loop_wrap_on", int'(loop_active), 1);

    step(7);
    play_1p = 1'b1;
    step(1);
    play_1p = 1'b0;
    check("pause_tick", int'(beat_tick), 0);
    check("pause_ibeat", int'(ibeat), 14);
    check("pause_playing", int'(playing), 0);
    check("pause_loop", int'(loop_active), 0);
    check("pause_no_tick", ntick, seen);
    step(3);
    check("paused_hold", int'(ibeat), 14);
    check("paused_no_tick", ntick, seen);

    push(1);
    pulse(1'b1, 1'b0, 1'b0);
    check("resume_play", int'(playing), 1);
    check("resume_loop", int'(loop_active), 1);
    last_c = cyc;
    wait_tick(8);

    push(0);
    push(15);
    repeat (2) pulse(1'b0, 1'b1, 1'b0);
    check("speed_lvl4", int'(speed_level), 4);
    wait_tick(0);
    wait_tick(2);

    #2 rst = 1'b0;
    #1;
    check("arst_ibeat", int'(ibeat), 0);
    check("arst_tick", int'(beat_tick), 0);
    check("arst_speed", int'(speed_level), 2);
    check("arst_playing", int'(playing), 0);
    check("arst_loop", int'(loop_active), 0);
    step(2);
    rst = 1'b1;
    step(10);
    check("post_ibeat", int'(ibeat), 0);
    check("post_playing", int'(playing), 0);
    check("post_no_tick", ntick, seen);
    check("sb_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
